data_mem_stage: RTL and testbench



---
 rtl/data_mem_stage_pkg.sv | 18 +
 rtl/data_mem_array.sv | 23 ++
 rtl/data_mem_stage.sv | 108 ++++++++++
 tb/tb_data_mem_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, default base
// address and the width helper used for the wait-state counter and word index.
package data_mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module data_mem_array
   import data_mem_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IDX_W = width_of(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_stage.sv
// Memory-stage responder: accepts a load/store from EXE/MEM, stalls the pipeline
// for the wait states, and presents registered load data to MEM/WB.
module data_mem_stage
   import data_mem_stage_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_STATES = 3,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] ALU_result,
   input  logic [31:0] ST_val,
   output logic [31:0] MEM_result,
   output logic        freeze,
   output logic        busy
);

   localparam int unsigned IDX_W = width_of(DEPTH);
   localparam int unsigned CNT_W = width_of(WAIT_STATES);

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      lat_data;
   logic             lat_store;

   logic             req;
   logic [31:0]      offset;
   logic [IDX_W-1:0] req_idx;
   logic             acc_en;
   logic             acc_store;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      acc_data;
   logic [31:0]      rdata;

   assign req     = MEM_R_EN | MEM_W_EN;
   assign offset  = ALU_result - BASE_ADDR;
   assign req_idx = IDX_W'(offset >> 2);

   // With no wait states the array is accessed on the acceptance edge itself,
   // so the access path takes the live request instead of the latched copy.
   always_comb begin
      acc_en    = 1'b0;
      acc_store = lat_store;
      acc_idx   = lat_idx;
      acc_data  = lat_data;
      if (state == IDLE) begin
         acc_en    = req && (WAIT_STATES == 0);
         acc_store = MEM_W_EN;
         acc_idx   = req_idx;
         acc_data  = ST_val;
      end else if (state == BUSY) begin
         acc_en = (counter == '0);
      end
   end

   data_mem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (acc_en & acc_store),
      .addr  (acc_idx),
      .wdata (acc_data),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         counter    <= '0;
         lat_idx    <= '0;
         lat_data   <= '0;
         lat_store  <= 1'b0;
         MEM_result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_idx   <= req_idx;
                  lat_data  <= ST_val;
                  lat_store <= MEM_W_EN;
                  if (WAIT_STATES > 0) begin
                     state   <= BUSY;
                     counter <= CNT_W'(WAIT_STATES - 1);
                  end else begin
                     state <= DONE;
                  end
               end
            end
            BUSY: begin
               if (counter == '0) state <= DONE;
               else               counter <= counter - 1'b1;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (acc_en && !acc_store) MEM_result <= rdata;
      end
   end

   assign freeze = rst & (((state == IDLE) & req) | (state == BUSY));
   assign busy   = (state == BUSY);

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: two instances (3 and 0 wait states) checked
// every cycle against an instruction-level timing and memory model.
module tb_data_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        r_en [2];
   logic        w_en [2];
   logic [31:0] addr [2];
   logic [31:0] st   [2];
   logic [31:0] res  [2];
   logic        frz  [2];
   logic        bsy  [2];

   int checks = 0;
   int errors = 0;

   logic [31:0] mmem      [2][64];
   bit          mwr       [2][64];
   bit          exp_freeze[2];
   bit          exp_busy  [2];
   logic [31:0] exp_res   [2];
   bit          res_known [2];

   always #5 clk = ~clk;

   data_mem_stage #(.DEPTH(64), .WAIT_STATES(3), .BASE_ADDR(32'd1024)) dut3 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
      .ALU_result(addr[0]), .ST_val(st[0]), .MEM_result(res[0]),
      .freeze(frz[0]), .busy(bsy[0]));

   data_mem_stage #(.DEPTH(64), .WAIT_STATES(0), .BASE_ADDR(32'd1024)) dut0 (
      .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
      .ALU_result(addr[1]), .ST_val(st[1]), .MEM_result(res[1]),
      .freeze(frz[1]), .busy(bsy[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - 32'd1024;
      return int'((off >> 2) % 32'd64);
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("freeze%0d", d), {31'b0, frz[d]}, {31'b0, exp_freeze[d]});
         chk($sformatf("busy%0d", d), {31'b0, bsy[d]}, {31'b0, exp_busy[d]});
         if (res_known[d]) chk($sformatf("mem_result%0d", d), res[d], exp_res[d]);
      end
   end

   // Called at posedge+1; holds the instruction through its freeze window and
   // its DONE cycle, then returns at posedge+1 of the following cycle.
   task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] v, input bit chg);
      int ws;
      int i;
      ws = (d == 0) ? 3 : 0;
      i  = idx_of(a);
      r_en[d] = r; w_en[d] = w; addr[d] = a; st[d] = v;
      for (int c = 0; c <= ws; c++) begin
         exp_freeze[d] = 1'b1;
         exp_busy[d]   = (c >= 1);
         @(posedge clk); #1;
         if (chg && c == 0) begin
            addr[d] = 32'd1100;
            st[d]   = 32'h0;
         end
      end
      exp_freeze[d] = 1'b0;
      exp_busy[d]   = 1'b0;
      if (w) begin
         mmem[d][i] = v;
         mwr[d][i]  = 1'b1;
      end else if (r) begin
         exp_res[d]   = mmem[d][i];
         res_known[d] = mwr[d][i];
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int d);
      r_en[d] = 1'b0; w_en[d] = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         r_en[d] = 1'b0; w_en[d] = 1'b0; addr[d] = '0; st[d] = '0;
         exp_freeze[d] = 1'b0; exp_busy[d] = 1'b0;
         exp_res[d] = '0; res_known[d] = 1'b1;
         for (int k = 0; k < 64; k++) begin
            mmem[d][k] = '0;
            mwr[d][k]  = 1'b0;
         end
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a store on the 3-wait-state instance
      w_en[0] = 1'b1; addr[0] = 32'd1024; st[0] = 32'hAAAA5555;
      exp_freeze[0] = 1'b1; exp_busy[0] = 1'b0;
      @(posedge clk); #1;
      exp_busy[0] = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      w_en[0] = 1'b0;
      #1;
      chk("reset_freeze", {31'b0, frz[0]}, 32'd0);
      chk("reset_busy", {31'b0, bsy[0]}, 32'd0);
      chk("reset_result", res[0], 32'd0);
      exp_freeze[0] = 1'b0; exp_busy[0] = 1'b0; exp_res[0] = '0;
      @(posedge clk); #1 rst = 1'b1;
      idle(0);

      access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      checks++;
      if (res[0] === 32'hAAAA5555) begin
         errors++;
         $display("FAIL discarded_store: got %h expected not aaaa5555", res[0]);
      end
      idle(0);

      // Store then load with wait states
      access(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
      idle(0);
      access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
      chk("load_1032", res[0], 32'hDEADBEEF);
      idle(0);

      // Aliasing and ignored low address bits, back-to-back
      access(0, 1'b0, 1'b1, 32'd1280, 32'h11, 1'b0);
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      chk("alias_load", res[0], 32'h11);
      access(0, 1'b1, 1'b0, 32'd1027, 32'h0, 1'b0);
      chk("misaligned_load", res[0], 32'h11);
      idle(0);

      // Both enables high acts as a store
      access(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
      access(0, 1'b1, 1'b1, 32'd1040, 32'h5A5A5A5A, 1'b0);
      chk("both_en_keeps_result", res[0], 32'hDEADBEEF);
      access(0, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
      chk("both_en_stored", res[0], 32'h5A5A5A5A);
      idle(0);

      // Inputs changed mid-access have no effect
      access(0, 1'b0, 1'b1, 32'd1100, 32'h19191919, 1'b0);
      access(0, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b1);
      idle(0);
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      chk("latched_store", res[0], 32'hCAFEF00D);
      access(0, 1'b1, 1'b0, 32'd1100, 32'h0, 1'b0);
      chk("word19_untouched", res[0], 32'h19191919);
      idle(0);

      // Zero wait states
      access(1, 1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0);
      idle(1);
      access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      chk("ws0_load", res[1], 32'h12345678);
      access(1, 1'b0, 1'b1, 32'd1028, 32'h28282828, 1'b0);
      access(1, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
      chk("ws0_b2b_first", res[1], 32'h28282828);
      access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      chk("ws0_b2b_second", res[1], 32'h12345678);
      idle(1);
      idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
